// File: rtl/rst_seq.sv
// Staged reset sequencer: waits for a stable PLL lock, then releases the
// downstream reset domains one by one; lock loss or a software request re-runs it.
module rst_seq #(
  parameter int NUM_STG  = 4,
  parameter int LOCK_CYC = 8,
  parameter int STG_DLY  = 16,
  parameter int HOLD_CYC = 32
) (
  input  logic               clk,
  input  logic               rst_asyn,
  input  logic               pll_lock,
  input  logic               sw_rst_req,
  output logic [NUM_STG-1:0] rst_n_out,
  output logic               seq_done,
  output logic               busy
);

  localparam int MAXC = (LOCK_CYC > STG_DLY) ?
                        ((LOCK_CYC > HOLD_CYC) ? LOCK_CYC : HOLD_CYC) :
                        ((STG_DLY  > HOLD_CYC) ? STG_DLY  : HOLD_CYC);
  localparam int CW = $clog2(MAXC) + 1;
  localparam int IW = $clog2(NUM_STG) + 1;

  typedef enum logic [1:0] {WAIT_LOCK, RELEASE, DONE, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          abort;

  assign abort = !pll_lock || sw_rst_req;

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (!pll_lock) cnt <= '0;
          else if (cnt == CW'(LOCK_CYC - 1)) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else cnt <= cnt + CW'(1);
        end
        RELEASE: begin
          // abort wins over a release falling on the same edge
          if (abort) begin
            state     <= HOLD;
            cnt       <= '0;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            busy      <= 1'b1;
          end else if (cnt == CW'(STG_DLY - 1)) begin
            cnt <= '0;
            idx <= idx + IW'(1);
            for (int i = 0; i < NUM_STG; i++)
              if (idx == IW'(i)) rst_n_out[i] <= 1'b1;
            if (idx == IW'(NUM_STG - 1)) begin
              state    <= DONE;
              seq_done <= 1'b1;
              busy     <= 1'b0;
            end
          end else cnt <= cnt + CW'(1);
        end
        DONE: begin
          if (abort) begin
            state     <= HOLD;
            cnt       <= '0;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        HOLD: begin
          // fixed-length hold; lock and requests are deliberately not sampled
          if (cnt == CW'(HOLD_CYC - 1)) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        end
        default: begin
          state     <= WAIT_LOCK;
          cnt       <= '0;
          idx       <= '0;
          rst_n_out <= '0;
          seq_done  <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed vector table, hand sequences for the corner
// cases, and a randomized run checked against a timeline-based model.
module tb_rst_seq;
  localparam int N = 4, LCK = 8, DLY = 16, HLD = 32;

  logic         clk = 1'b0;
  logic         rst_asyn, pll_lock, sw_rst_req;
  logic [N-1:0] rst_n_out;
  logic         seq_done, busy;

  rst_seq #(.NUM_STG(N), .LOCK_CYC(LCK), .STG_DLY(DLY), .HOLD_CYC(HLD)) dut (
    .clk(clk), .rst_asyn(rst_asyn), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .rst_n_out(rst_n_out), .seq_done(seq_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // model: phase 0 = waiting for lock, 1 = sequencing/done, 2 = hold
  int ph = 0, lock_run = 0, seq_t = 0, hold_t = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mexp();
    int nrel;
    logic [N-1:0] o;
    logic d;
    if (ph != 1) return {26'd0, {N{1'b0}}, 1'b0, 1'b1};
    nrel = seq_t / DLY;
    if (nrel > N) nrel = N;
    o = N'((1 << nrel) - 1);
    d = (nrel == N);
    return {26'd0, o, d, !d};
  endfunction

  task automatic model_edge(input logic l, input logic s);
    case (ph)
      0: begin
        lock_run = l ? lock_run + 1 : 0;
        if (lock_run == LCK) begin ph = 1; seq_t = 0; lock_run = 0; end
      end
      1: begin
        if (!l || s) begin ph = 2; hold_t = 0; end
        else if (seq_t < 100000) seq_t++;
      end
      default: begin
        hold_t++;
        if (hold_t == HLD) begin ph = 0; lock_run = 0; end
      end
    endcase
  endtask

  task automatic step(input logic l, input logic s);
    pll_lock = l; sw_rst_req = s;
    @(posedge clk);
    model_edge(l, s);
    #1 chk("model", {26'd0, rst_n_out, seq_done, busy}, mexp());
  endtask

  // reset pulse entirely between two rising edges
  task automatic mid_reset();
    #1 rst_asyn = 1'b0;
    #1 chk("async_clear", {26'd0, rst_n_out, seq_done, busy}, {26'd0, {N{1'b0}}, 1'b0, 1'b1});
    ph = 0; lock_run = 0;
    #1 rst_asyn = 1'b1;
  endtask

  task automatic tchk(input string nm, input logic [N-1:0] o, input logic d, input logic b);
    chk(nm, {26'd0, rst_n_out, seq_done, busy}, {26'd0, o, d, b});
  endtask

  typedef struct {
    logic lock; logic sw; int n; logic [N-1:0] out; logic done; logic bsy;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl.push_back('{1'b1, 1'b0, 23, 4'h0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0,  1, 4'h1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 15, 4'h1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0,  1, 4'h3, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 16, 4'h7, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 15, 4'h7, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0,  1, 4'hf, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0,  5, 4'hf, 1'b1, 1'b0});
    // software reset in DONE, hold + lock + gap before stage 0 again
    tbl.push_back('{1'b1, 1'b1,  1, 4'h0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 55, 4'h0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0,  1, 4'h1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 16, 4'h3, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 15, 4'h3, 1'b0, 1'b1});
    // lock lost on the edge stage 2 would release
    tbl.push_back('{1'b0, 1'b0,  1, 4'h0, 1'b0, 1'b1});

    pll_lock = 1'b1; sw_rst_req = 1'b0; rst_asyn = 1'b1;
    #1 rst_asyn = 1'b0;
    #1 tchk("reset_vals", 4'h0, 1'b0, 1'b1);
    #1 rst_asyn = 1'b1;

    foreach (tbl[v]) begin
      for (int c = 0; c < tbl[v].n; c++) step(tbl[v].lock, tbl[v].sw);
      chk($sformatf("tbl%0d", v), {26'd0, rst_n_out, seq_done, busy},
          {26'd0, tbl[v].out, tbl[v].done, tbl[v].bsy});
    end

    // requests and lock toggles during HOLD must not change its length
    for (int c = 0; c < 31; c++) step(c[0], c[1]);
    step(1'b1, 1'b1);
    tchk("hold_end", 4'h0, 1'b0, 1'b1);
    for (int c = 0; c < 23; c++) step(1'b1, 1'b0);
    tchk("post_hold_pre", 4'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    tchk("post_hold_s0", 4'h1, 1'b0, 1'b1);

    // async reset while stage 0 is out, then a lock glitch on restart
    mid_reset();
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int c = 0; c < 23; c++) step(1'b1, 1'b0);
    tchk("glitch_pre", 4'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    tchk("glitch_s0", 4'h1, 1'b0, 1'b1);

    for (int c = 0; c < 4000; c++) begin
      step(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 199) == 0));
      if ($urandom_range(0, 499) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
